// File: rtl/gravsim_pkg.sv
// Shared types and register-map constants for the gravity-sim display path.
package gravsim_pkg;

  localparam int unsigned COORD_W       = 10;
  localparam int unsigned REG_W         = 32;
  localparam int unsigned X_LSB         = 0;
  localparam int unsigned Y_LSB         = 16;
  localparam int unsigned EN_BIT        = 31;
  localparam int unsigned CTRL_ADDR_OFS = 0;

  typedef struct packed {
    logic               enable;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } body_t;

  // Software-visible image of a body register; unused bits read as zero.
  function automatic logic [REG_W-1:0] pack_body(input body_t b);
    logic [REG_W-1:0] r;
    r                   = '0;
    r[X_LSB +: COORD_W] = b.x;
    r[Y_LSB +: COORD_W] = b.y;
    r[EN_BIT]           = b.enable;
    return r;
  endfunction

endpackage

// File: rtl/body_hit_pipe.sv
// Per-body two-stage distance-squared pipeline; hit flag is the stage-3 compare.
module body_hit_pipe
  import gravsim_pkg::*;
#(
  parameter int unsigned RADIUS = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  body_t              body_i,
  input  logic [COORD_W-1:0] draw_x_i,
  input  logic [COORD_W-1:0] draw_y_i,
  output logic               hit_o
);

  localparam int unsigned DIFF_W = COORD_W + 1;
  localparam int unsigned SUM_W  = 2 * COORD_W + 1;
  localparam logic [SUM_W-1:0] R_SQ = SUM_W'(RADIUS * RADIUS);

  logic signed [DIFF_W-1:0] dx_c, dy_c;
  logic [COORD_W-1:0]       adx_d, adx_q, ady_d, ady_q;
  logic [SUM_W-1:0]         adx_w, ady_w, sq_d, sq_q;
  logic                     en1_q, en2_q;

  // Signed differences so bodies near the screen edge clip instead of wrapping.
  always_comb begin
    dx_c  = $signed({1'b0, draw_x_i}) - $signed({1'b0, body_i.x});
    dy_c  = $signed({1'b0, draw_y_i}) - $signed({1'b0, body_i.y});
    adx_d = dx_c[DIFF_W-1] ? COORD_W'(-dx_c) : dx_c[COORD_W-1:0];
    ady_d = dy_c[DIFF_W-1] ? COORD_W'(-dy_c) : dy_c[COORD_W-1:0];
  end

  always_comb begin
    adx_w = SUM_W'(adx_q);
    ady_w = SUM_W'(ady_q);
    sq_d  = adx_w * adx_w + ady_w * ady_w;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      adx_q <= '0;
      ady_q <= '0;
      en1_q <= 1'b0;
      sq_q  <= '0;
      en2_q <= 1'b0;
    end else begin
      adx_q <= adx_d;
      ady_q <= ady_d;
      en1_q <= body_i.enable;
      sq_q  <= sq_d;
      en2_q <= en1_q;
    end
  end

  assign hit_o = en2_q && (sq_q <= R_SQ);

endmodule

// File: rtl/ball_renderer.sv
// Avalon-mapped body registers with vsync-aligned commit, feeding per-body hit
// pipelines and a lowest-index priority encoder for color_mapper.
module ball_renderer
  import gravsim_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned RADIUS   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        VGA_VS,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_ball,
  output logic [3:0]  ball_id,
  output logic [15:0] frame_count
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned FC_W   = 16;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(N_BODIES + CTRL_ADDR_OFS);

  body_t             shadow_q [N_BODIES];
  body_t             shadow_d [N_BODIES];
  body_t             active_q [N_BODIES];
  body_t             active_d [N_BODIES];
  logic              pending_q, pending_d;
  logic              vs_q;
  logic [FC_W-1:0]   frame_q, frame_d;
  logic              vs_fall_c;
  logic [ADDR_W-1:0] wr_addr_w, rd_addr_w;

  logic [N_BODIES-1:0] hit_c;
  logic                is_ball_q, is_ball_d;
  logic [ID_W-1:0]     ball_id_q, ball_id_d;
  logic                unused_wr_bits;

  assign unused_wr_bits = ^wr_data;
  assign wr_addr_w      = {1'b0, wr_addr};
  assign rd_addr_w      = {1'b0, rd_addr};
  assign vs_fall_c      = vs_q & ~VGA_VS;

  // Commit copies pre-write shadow; a same-cycle commit write re-arms pending.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    if (vs_fall_c) begin
      frame_d = frame_q + FC_W'(1);
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
    if (wr_en) begin
      for (int unsigned i = 0; i < N_BODIES; i++) begin
        if (wr_addr_w == ADDR_W'(i)) begin
          shadow_d[i].x      = wr_data[X_LSB +: COORD_W];
          shadow_d[i].y      = wr_data[Y_LSB +: COORD_W];
          shadow_d[i].enable = wr_data[EN_BIT];
        end
      end
      if (wr_addr_w == CTRL_ADDR && wr_data[0]) begin
        pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < N_BODIES; i++) begin
      if (rd_addr_w == ADDR_W'(i)) begin
        rd_data = pack_body(shadow_q[i]);
      end
    end
    if (rd_addr_w == CTRL_ADDR) begin
      rd_data = {pending_q, 15'b0, frame_q};
    end
  end

  for (genvar g = 0; g < N_BODIES; g++) begin : g_body
    body_hit_pipe #(
      .RADIUS (RADIUS)
    ) u_pipe (
      .Clk      (Clk),
      .Reset    (Reset),
      .body_i   (active_q[g]),
      .draw_x_i (DrawX),
      .draw_y_i (DrawY),
      .hit_o    (hit_c[g])
    );
  end

  // Lowest index wins when discs overlap.
  always_comb begin
    is_ball_d = |hit_c;
    ball_id_d = '0;
    for (int i = N_BODIES - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        ball_id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_BODIES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
      vs_q      <= 1'b1;
      frame_q   <= '0;
      is_ball_q <= 1'b0;
      ball_id_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      vs_q      <= VGA_VS;
      frame_q   <= frame_d;
      is_ball_q <= is_ball_d;
      ball_id_q <= ball_id_d;
    end
  end

  assign is_ball     = is_ball_q;
  assign ball_id     = ball_id_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer with a per-cycle behavioural reference model.
module tb_ball_renderer;

  localparam int N = 4;
  localparam int R = 4;

  logic        Clk     = 1'b0;
  logic        Reset   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        VGA_VS  = 1'b1;
  logic [9:0]  DrawX   = '0;
  logic [9:0]  DrawY   = '0;
  logic        is_ball;
  logic [3:0]  ball_id;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  ball_renderer #(
    .N_BODIES (N),
    .RADIUS   (R)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .VGA_VS      (VGA_VS),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .is_ball     (is_ball),
    .ball_id     (ball_id),
    .frame_count (frame_count)
  );

  // Reference state: software view of bodies plus what the screen shows.
  int sx [N];
  int sy [N];
  bit sen[N];
  int ax [N];
  int ay [N];
  bit aen[N];
  bit m_pend;
  int m_fc;
  bit m_vs;
  bit ph [3];
  int pid[3];

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sen[i] = 0;
      ax[i] = 0; ay[i] = 0; aen[i] = 0;
    end
    m_pend = 0;
    m_fc   = 0;
    m_vs   = 1;
    for (int k = 0; k < 3; k++) begin
      ph[k]  = 0;
      pid[k] = 0;
    end
  endtask

  function automatic logic [31:0] mread(input int a);
    logic [31:0] r;
    r = '0;
    if (a < N) begin
      r = {sen[a], 5'b0, 10'(sy[a]), 6'b0, 10'(sx[a])};
    end else if (a == N) begin
      r = {m_pend, 15'b0, 16'(m_fc)};
    end
    return r;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_reset();
    end else begin
      bit h;
      int id;
      bit np;
      h  = 0;
      id = 0;
      for (int i = N - 1; i >= 0; i--) begin
        int dx, dy;
        dx = int'(DrawX) - ax[i];
        dy = int'(DrawY) - ay[i];
        if (aen[i] && (dx * dx + dy * dy <= R * R)) begin
          h  = 1;
          id = i;
        end
      end
      np = m_pend;
      if (m_vs && !VGA_VS) begin
        m_fc = (m_fc + 1) % 65536;
        if (m_pend) begin
          for (int i = 0; i < N; i++) begin
            ax[i] = sx[i]; ay[i] = sy[i]; aen[i] = sen[i];
          end
          np = 0;
        end
      end
      if (wr_en) begin
        if (int'(wr_addr) < N) begin
          sx[wr_addr]  = int'(wr_data[9:0]);
          sy[wr_addr]  = int'(wr_data[25:16]);
          sen[wr_addr] = wr_data[31];
        end else if (int'(wr_addr) == N && wr_data[0]) begin
          np = 1;
        end
      end
      m_pend = np;
      m_vs   = VGA_VS;
      ph[2]  = ph[1];  ph[1]  = ph[0];  ph[0]  = h;
      pid[2] = pid[1]; pid[1] = pid[0]; pid[0] = id;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("model_is_ball", 32'(is_ball), 32'(ph[2]));
    chk("model_ball_id", 32'(ball_id), 32'(pid[2]));
    chk("model_frame_count", 32'(frame_count), 32'(m_fc));
    chk("model_rd_data", rd_data, mread(int'(rd_addr)));
  end

  function automatic logic [31:0] body(input bit en, input int x, input int y);
    return {en, 5'b0, 10'(y), 6'b0, 10'(x)};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic commit();
    wr(N, 32'h1);
  endtask

  task automatic vs_edge();
    VGA_VS = 1'b0;
    cyc();
    cyc();
    VGA_VS = 1'b1;
    cyc();
  endtask

  task automatic hold_chk(input string nm, input int x, input int y, input bit eh, input int eid);
    DrawX = 10'(x);
    DrawY = 10'(y);
    repeat (3) cyc();
    chk({nm, "_hit"}, 32'(is_ball), 32'(eh));
    chk({nm, "_id"}, 32'(ball_id), 32'(eid));
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] exp);
    rd_addr = 4'(a);
    #1;
    chk(nm, rd_data, exp);
  endtask

  initial begin
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    cyc();
    chk("rst_fc", 32'(frame_count), 32'h0);
    chk("rst_is_ball", 32'(is_ball), 32'h0);
    rd_chk("rst_ctrl", N, 32'h0);
    rd_chk("rst_body0", 0, 32'h0);

    wr(0, body(1, 100, 50));
    rd_chk("shadow0", 0, 32'h8032_0064);
    commit();
    rd_chk("pend_set", N, 32'h8000_0000);
    vs_edge();
    rd_chk("pend_clr", N, 32'h0000_0001);

    for (int x = 90; x <= 110; x++) begin
      DrawX = 10'(x);
      DrawY = 10'd50;
      cyc();
    end
    repeat (3) cyc();
    for (int x = 90; x <= 110; x++) begin
      hold_chk("sweep", x, 50, (x >= 96 && x <= 104), 0);
    end

    wr(1, body(1, 100, 50));
    commit();
    vs_edge();
    hold_chk("overlap", 100, 50, 1, 0);
    wr(0, body(0, 100, 50));
    commit();
    vs_edge();
    hold_chk("overlap_dis", 100, 50, 1, 1);

    wr(1, body(1, 200, 50));
    vs_edge();
    vs_edge();
    hold_chk("stale", 100, 50, 1, 1);
    hold_chk("stale_new", 200, 50, 0, 0);
    rd_chk("fc_plus2", N, 32'h0000_0005);
    commit();
    vs_edge();
    hold_chk("moved", 200, 50, 1, 1);
    hold_chk("moved_old", 100, 50, 0, 0);

    wr(2, body(1, 2, 2));
    commit();
    commit();
    vs_edge();
    rd_chk("collapse", N, 32'h0000_0007);
    vs_edge();
    rd_chk("collapse_next", N, 32'h0000_0008);
    hold_chk("corner", 0, 0, 1, 2);
    hold_chk("corner_miss", 7, 2, 0, 0);

    wr(3, 32'hFFFF_FFFF);
    rd_chk("mask", 3, 32'h83FF_03FF);
    wr(9, 32'hFFFF_FFFF);
    rd_chk("hi_addr", 9, 32'h0);

    wr(2, body(1, 20, 20));
    commit();
    VGA_VS = 1'b0;
    commit();
    cyc();
    VGA_VS = 1'b1;
    cyc();
    rd_chk("pend_on_edge", N, 32'h8000_0009);
    hold_chk("edge_copy", 20, 20, 1, 2);
    wr(2, body(1, 300, 20));
    vs_edge();
    rd_chk("pend_after", N, 32'h0000_000A);
    hold_chk("next_copy", 300, 20, 1, 2);
    hold_chk("next_old", 20, 20, 0, 0);

    wr(2, body(1, 400, 20));
    commit();
    VGA_VS = 1'b0;
    wr(2, body(1, 500, 20));
    cyc();
    VGA_VS = 1'b1;
    cyc();
    hold_chk("pre_write", 400, 20, 1, 2);
    hold_chk("pre_write_new", 500, 20, 0, 0);
    rd_chk("shadow_new", 2, 32'h8014_01F4);

    DrawX = 10'd400;
    DrawY = 10'd20;
    repeat (3) cyc();
    chk("pre_rst_hit", 32'(is_ball), 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_hit", 32'(is_ball), 32'h0);
    chk("async_rst_id", 32'(ball_id), 32'h0);
    chk("async_rst_fc", 32'(frame_count), 32'h0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    cyc();
    for (int a = 0; a < 16; a++) begin
      rd_chk("rst_rd", a, 32'h0);
      cyc();
    end
    hold_chk("rst_pix", 400, 20, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
